// File: rtl/if_id_buffer_if.sv
// Fetch/hazard-unit to decode handshake bundle for if_id_buffer.
// master = fetch stage + hazard unit side, slave = the buffer itself.
interface if_id_buffer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PCF;
  logic [WIDTH-1:0] PC_add_4F;
  logic [WIDTH-1:0] instrF;
  logic             missF;
  logic             StallD;
  logic             FlushD;
  logic             bufFull;
  logic [WIDTH-1:0] PCD;
  logic [WIDTH-1:0] PC_add_4D;
  logic [WIDTH-1:0] instrD;
  logic             validD;
  logic             AdELD;

  modport master (
    output PCF, PC_add_4F, instrF, missF, StallD, FlushD,
    input  bufFull, PCD, PC_add_4D, instrD, validD, AdELD
  );

  modport slave (
    input  PCF, PC_add_4F, instrF, missF, StallD, FlushD,
    output bufFull, PCD, PC_add_4D, instrD, validD, AdELD
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO feeding the ID pipeline register; cache misses become bubbles.
// Optional fetch address-error tagging is enabled by defining IF_ID_ADEL_EN.
module if_id_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  if_id_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] pc4_mem   [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] pcd_q;
  logic [WIDTH-1:0] pc4d_q;
  logic [WIDTH-1:0] instrd_q;
  logic             validd_q;

  logic             in_f;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             bypass;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [WIDTH-1:0] instr_in;

`ifdef IF_ID_ADEL_EN
  logic             adel_mem [DEPTH];
  logic             adel_in;
  logic             adeld_q;
`endif

  // full comes only from registered count so fetch stall has no combinational loop
  assign in_f    = !bus.missF;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign enq     = in_f && !full && !bus.FlushD;
  assign deq     = !bus.StallD && (!empty || enq);
  assign bypass  = empty && enq && !bus.StallD;
  assign fifo_wr = enq && !bypass;
  assign fifo_rd = deq && !bypass;

`ifdef IF_ID_ADEL_EN
  assign adel_in  = (bus.PCF[1:0] != 2'b00);
  assign instr_in = adel_in ? '0 : bus.instrF;
`else
  assign instr_in = bus.instrF;
`endif

  // Storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      pc_mem[wr_ptr]    <= bus.PCF;
      pc4_mem[wr_ptr]   <= bus.PC_add_4F;
      instr_mem[wr_ptr] <= instr_in;
`ifdef IF_ID_ADEL_EN
      adel_mem[wr_ptr]  <= adel_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pcd_q    <= '0;
      pc4d_q   <= '0;
      instrd_q <= '0;
      validd_q <= 1'b0;
`ifdef IF_ID_ADEL_EN
      adeld_q  <= 1'b0;
`endif
    end else if (bus.FlushD) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      instrd_q <= '0;
      validd_q <= 1'b0;
`ifdef IF_ID_ADEL_EN
      adeld_q  <= 1'b0;
`endif
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_wr && !fifo_rd)      count <= count + CNT_W'(1);
      else if (fifo_rd && !fifo_wr) count <= count - CNT_W'(1);

      // ID register: bypass beats FIFO head; an idle non-stalled cycle inserts a bubble
      if (bypass) begin
        pcd_q    <= bus.PCF;
        pc4d_q   <= bus.PC_add_4F;
        instrd_q <= instr_in;
        validd_q <= 1'b1;
`ifdef IF_ID_ADEL_EN
        adeld_q  <= adel_in;
`endif
      end else if (fifo_rd) begin
        pcd_q    <= pc_mem[rd_ptr];
        pc4d_q   <= pc4_mem[rd_ptr];
        instrd_q <= instr_mem[rd_ptr];
        validd_q <= 1'b1;
`ifdef IF_ID_ADEL_EN
        adeld_q  <= adel_mem[rd_ptr];
`endif
      end else if (!bus.StallD) begin
        instrd_q <= '0;
        validd_q <= 1'b0;
`ifdef IF_ID_ADEL_EN
        adeld_q  <= 1'b0;
`endif
      end
    end
  end

  assign bus.bufFull   = full;
  assign bus.PCD       = pcd_q;
  assign bus.PC_add_4D = pc4d_q;
  assign bus.instrD    = instrd_q;
  assign bus.validD    = validd_q;
`ifdef IF_ID_ADEL_EN
  assign bus.AdELD     = adeld_q;
`else
  assign bus.AdELD     = 1'b0;
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed table-driven bench for if_id_buffer (DEPTH=2), plus hand-written miss-during-stall sequences.
// Expected AdELD/instrD for misaligned PCs follow IF_ID_ADEL_EN.
module tb_if_id_buffer;
`ifdef IF_ID_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        miss;
    logic        stall;
    logic        flush;
    logic        e_full;
    logic        e_valid;
    logic [31:0] e_pcd;
    logic [31:0] e_pc4d;
    logic [31:0] e_instr;
    logic        e_adel;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  if_id_buffer_if #(.WIDTH(32)) bus ();

  if_id_buffer #(.WIDTH(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic [31:0] pc, logic [31:0] instr,
                              logic miss, logic stall, logic flush, logic e_full,
                              logic e_valid, logic [31:0] e_pcd, logic [31:0] e_instr,
                              logic e_adel);
    vec_t v;
    v.name    = name;
    v.rst     = r;
    v.pc      = pc;
    v.instr   = instr;
    v.miss    = miss;
    v.stall   = stall;
    v.flush   = flush;
    v.e_full  = e_full;
    v.e_valid = e_valid;
    v.e_pcd   = e_pcd;
    v.e_pc4d  = (e_pcd == 32'h0) ? 32'h0 : e_pcd + 32'd4;
    v.e_instr = e_instr;
    v.e_adel  = e_adel;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.PCF       = v.pc;
    bus.PC_add_4F = v.pc + 32'd4;
    bus.instrF    = v.instr;
    bus.missF     = v.miss;
    bus.StallD    = v.stall;
    bus.FlushD    = v.flush;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    checkOne({v.name, ".bufFull"},   32'(bus.bufFull), 32'(v.e_full));
    checkOne({v.name, ".validD"},    32'(bus.validD),  32'(v.e_valid));
    checkOne({v.name, ".PCD"},       bus.PCD,          v.e_pcd);
    checkOne({v.name, ".PC_add_4D"}, bus.PC_add_4D,    v.e_pc4d);
    checkOne({v.name, ".instrD"},    bus.instrD,       v.e_instr);
    checkOne({v.name, ".AdELD"},     32'(bus.AdELD),   32'(v.e_adel));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.PCF       = '0;
    bus.PC_add_4F = '0;
    bus.instrF    = '0;
    bus.missF     = 1'b1;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;

    //            name       rst pc            instr         ms st fl  full val pcd           instrD        adel
    vecs.push_back(mk("reset",   1, 32'h0,        32'h0,        1, 0, 0,  0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk("str0",    0, 32'hbfc00000, 32'h24080000, 0, 0, 0,  0, 1, 32'hbfc00000, 32'h24080000, 0));
    vecs.push_back(mk("str1",    0, 32'hbfc00004, 32'h24080001, 0, 0, 0,  0, 1, 32'hbfc00004, 32'h24080001, 0));
    vecs.push_back(mk("str2",    0, 32'hbfc00008, 32'h24080002, 0, 0, 0,  0, 1, 32'hbfc00008, 32'h24080002, 0));
    vecs.push_back(mk("miss0",   0, 32'hbfc0000c, 32'hdeadbeef, 1, 0, 0,  0, 0, 32'hbfc00008, 32'h0,        0));
    vecs.push_back(mk("miss1",   0, 32'hbfc0000c, 32'hdeadbeef, 1, 0, 0,  0, 0, 32'hbfc00008, 32'h0,        0));
    vecs.push_back(mk("miss2",   0, 32'hbfc0000c, 32'hdeadbeef, 1, 0, 0,  0, 0, 32'hbfc00008, 32'h0,        0));
    vecs.push_back(mk("hit",     0, 32'hbfc0000c, 32'h24080003, 0, 0, 0,  0, 1, 32'hbfc0000c, 32'h24080003, 0));
    vecs.push_back(mk("stall0",  0, 32'hbfc00010, 32'h24080004, 0, 1, 0,  0, 1, 32'hbfc0000c, 32'h24080003, 0));
    vecs.push_back(mk("stall1",  0, 32'hbfc00014, 32'h24080005, 0, 1, 0,  1, 1, 32'hbfc0000c, 32'h24080003, 0));
    vecs.push_back(mk("stall2",  0, 32'hbfc00018, 32'h24080006, 0, 1, 0,  1, 1, 32'hbfc0000c, 32'h24080003, 0));
    vecs.push_back(mk("stall3",  0, 32'hbfc00018, 32'h24080006, 0, 1, 0,  1, 1, 32'hbfc0000c, 32'h24080003, 0));
    vecs.push_back(mk("drain0",  0, 32'hbfc00018, 32'h24080006, 0, 0, 0,  0, 1, 32'hbfc00010, 32'h24080004, 0));
    vecs.push_back(mk("drain1",  0, 32'hbfc00018, 32'h24080006, 0, 0, 0,  0, 1, 32'hbfc00014, 32'h24080005, 0));
    vecs.push_back(mk("drain2",  0, 32'hbfc0001c, 32'h24080007, 0, 0, 0,  0, 1, 32'hbfc00018, 32'h24080006, 0));
    vecs.push_back(mk("drain3",  0, 32'hbfc00020, 32'hdeadbeef, 1, 0, 0,  0, 1, 32'hbfc0001c, 32'h24080007, 0));
    vecs.push_back(mk("fill0",   0, 32'hbfc00020, 32'h24080008, 0, 1, 0,  0, 1, 32'hbfc0001c, 32'h24080007, 0));
    vecs.push_back(mk("fill1",   0, 32'hbfc00024, 32'h24080009, 0, 1, 0,  1, 1, 32'hbfc0001c, 32'h24080007, 0));
    vecs.push_back(mk("flush",   0, 32'hbfc00028, 32'h2408000a, 0, 1, 1,  0, 0, 32'hbfc0001c, 32'h0,        0));
    vecs.push_back(mk("redir",   0, 32'hbfc00380, 32'h2408000b, 0, 0, 0,  0, 1, 32'hbfc00380, 32'h2408000b, 0));
    vecs.push_back(mk("adel",    0, 32'hbfc00002, 32'h2408000c, 0, 0, 0,  0, 1, 32'hbfc00002,
                      ADEL ? 32'h0 : 32'h2408000c, ADEL));
    vecs.push_back(mk("aligned", 0, 32'hbfc00004, 32'h2408000d, 0, 0, 0,  0, 1, 32'hbfc00004, 32'h2408000d, 0));
    vecs.push_back(mk("rfill0",  0, 32'hbfc00008, 32'h2408000e, 0, 1, 0,  0, 1, 32'hbfc00004, 32'h2408000d, 0));
    vecs.push_back(mk("rfill1",  0, 32'hbfc0000c, 32'h2408000f, 0, 1, 0,  1, 1, 32'hbfc00004, 32'h2408000d, 0));
    vecs.push_back(mk("rstmid",  1, 32'hbfc00010, 32'h24080010, 0, 1, 0,  0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk("post",    0, 32'hbfc00000, 32'h24080000, 0, 0, 0,  0, 1, 32'hbfc00000, 32'h24080000, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Misses during a stall must not occupy slots; releasing then yields the buffered word and a bubble
    applyStimulus(mk("sq_st",  0, 32'hbfc00004, 32'h24080001, 0, 1, 0, 0, 1, 32'hbfc00000, 32'h24080000, 0));
    checkOutput(mk("sq_st",    0, 32'hbfc00004, 32'h24080001, 0, 1, 0, 0, 1, 32'hbfc00000, 32'h24080000, 0));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mk("sq_ms", 0, 32'hbfc00008, 32'hdeadbeef, 1, 1, 0, 0, 1, 32'hbfc00000, 32'h24080000, 0));
      checkOutput(mk("sq_ms",   0, 32'hbfc00008, 32'hdeadbeef, 1, 1, 0, 0, 1, 32'hbfc00000, 32'h24080000, 0));
    end
    applyStimulus(mk("sq_rel", 0, 32'hbfc00008, 32'hdeadbeef, 1, 0, 0, 0, 1, 32'hbfc00004, 32'h24080001, 0));
    checkOutput(mk("sq_rel",   0, 32'hbfc00008, 32'hdeadbeef, 1, 0, 0, 0, 1, 32'hbfc00004, 32'h24080001, 0));
    applyStimulus(mk("sq_bub", 0, 32'hbfc00008, 32'hdeadbeef, 1, 0, 0, 0, 0, 32'hbfc00004, 32'h0,        0));
    checkOutput(mk("sq_bub",   0, 32'hbfc00008, 32'hdeadbeef, 1, 0, 0, 0, 0, 32'hbfc00004, 32'h0,        0));

    // Flush without stall drops the same-cycle fetch instead of bypassing it
    applyStimulus(mk("sq_fl",  0, 32'hbfc00008, 32'h24080002, 0, 0, 1, 0, 0, 32'hbfc00004, 32'h0,        0));
    checkOutput(mk("sq_fl",    0, 32'hbfc00008, 32'h24080002, 0, 0, 1, 0, 0, 32'hbfc00004, 32'h0,        0));
    applyStimulus(mk("sq_nx",  0, 32'hbfc00100, 32'h24080020, 0, 0, 0, 0, 1, 32'hbfc00100, 32'h24080020, 0));
    checkOutput(mk("sq_nx",    0, 32'hbfc00100, 32'h24080020, 0, 0, 0, 0, 1, 32'hbfc00100, 32'h24080020, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
